// File: rtl/nrisc_control_alu_if.sv
// Bundle of the decode/ALU signals shared between the datapath driver and
// the nrisc control + ALU block.
interface nrisc_control_alu_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] mem_data;

    logic [1:0]       ula_op;
    logic             gz;
    logic             esc_pc;
    logic             esc_mem;
    logic             ler_mem;
    logic             esc_reg;
    logic             reg_fonte;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             branch_taken;
    logic [WIDTH-1:0] wb_data;
    logic             halted;

    modport master (
        output opcode, alu_a, alu_b, mem_data,
        input  ula_op, gz, esc_pc, esc_mem, ler_mem, esc_reg, reg_fonte,
        input  alu_out, zero, branch_taken, wb_data, halted
    );

    modport slave (
        input  opcode, alu_a, alu_b, mem_data,
        output ula_op, gz, esc_pc, esc_mem, ler_mem, esc_reg, reg_fonte,
        output alu_out, zero, branch_taken, wb_data, halted
    );
endinterface

// File: rtl/nrisc_control_alu.sv
// Combinational opcode decode, ALU and write-back mux for the nrisc core;
// the only state is the sticky halt flag.
module nrisc_control_alu #(
    parameter int WIDTH = 8
) (
    input logic                CLK,
    input logic                RESET,
    nrisc_control_alu_if.slave bus
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_LW   = 3'b011,
        OP_SW   = 3'b100,
        OP_BGZ  = 3'b101,
        OP_NOP  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    logic             halted_q;
    logic             halted_d;

    logic [1:0]       dec_ula_op;
    logic             dec_esc_reg;
    logic             dec_reg_fonte;
    logic             dec_ler_mem;
    logic             dec_esc_mem;
    logic             dec_gz;
    logic             dec_esc_pc;

    logic             run;
    logic [1:0]       ula_op;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] alu_out;

    always_comb begin
        dec_ula_op    = 2'b00;
        dec_esc_reg   = 1'b0;
        dec_reg_fonte = 1'b0;
        dec_ler_mem   = 1'b0;
        dec_esc_mem   = 1'b0;
        dec_gz        = 1'b0;
        dec_esc_pc    = 1'b1;
        case (opcode_e'(bus.opcode))
            OP_ADD: begin
                dec_esc_reg = 1'b1;
            end
            OP_SUB: begin
                dec_ula_op  = 2'b01;
                dec_esc_reg = 1'b1;
            end
            OP_MUL: begin
                dec_ula_op  = 2'b10;
                dec_esc_reg = 1'b1;
            end
            OP_LW: begin
                dec_esc_reg   = 1'b1;
                dec_reg_fonte = 1'b1;
                dec_ler_mem   = 1'b1;
            end
            OP_SW: begin
                dec_esc_mem = 1'b1;
            end
            OP_BGZ: begin
                dec_ula_op = 2'b11;
                dec_gz     = 1'b1;
            end
            OP_NOP: begin
            end
            OP_HALT: begin
                dec_esc_pc = 1'b0;
            end
            default: begin
                dec_esc_pc = 1'b0;
            end
        endcase
    end

    // Reset and halt both force every control line to its inert value.
    assign run = RESET & ~halted_q;

    always_comb begin
        halted_d = halted_q;
        if (bus.opcode == OP_HALT) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign ula_op = run ? dec_ula_op : 2'b00;
    assign prod   = {{WIDTH{1'b0}}, bus.alu_a} * {{WIDTH{1'b0}}, bus.alu_b};

    always_comb begin
        alu_out = bus.alu_a;
        case (ula_op)
            2'b00:   alu_out = bus.alu_a + bus.alu_b;
            2'b01:   alu_out = bus.alu_a - bus.alu_b;
            2'b10:   alu_out = prod[WIDTH-1:0];
            default: alu_out = bus.alu_a;
        endcase
    end

    assign bus.ula_op       = ula_op;
    assign bus.esc_reg      = run & dec_esc_reg;
    assign bus.reg_fonte    = run & dec_reg_fonte;
    assign bus.ler_mem      = run & dec_ler_mem;
    assign bus.esc_mem      = run & dec_esc_mem;
    assign bus.gz           = run & dec_gz;
    assign bus.esc_pc       = run & dec_esc_pc;
    assign bus.alu_out      = alu_out;
    assign bus.zero         = (alu_out == '0);
    // Positive in two's complement: non-zero with a clear sign bit.
    assign bus.branch_taken = run & dec_gz & (alu_out != '0) & ~alu_out[WIDTH-1];
    assign bus.wb_data      = (run & dec_reg_fonte) ? bus.mem_data : alu_out;
    assign bus.halted       = halted_q;

endmodule

// File: tb/tb_nrisc_control_alu.sv
// Directed + random checks of the nrisc control/ALU block against a table
// model, with expected vectors queued at drive time and popped at sampling.
module tb_nrisc_control_alu;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;
    logic hm;
    logic [26:0] sb_q[$];

    nrisc_control_alu_if #(.WIDTH(8)) bus ();

    nrisc_control_alu #(.WIDTH(8)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference halt flag, tracked independently from the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hm <= 1'b0;
        else if (bus.opcode == 3'b111) hm <= 1'b1;
    end

    // Packed as {ula_op, gz, esc_pc, esc_mem, ler_mem, esc_reg, reg_fonte,
    //            alu_out, zero, branch_taken, wb_data, halted}.
    function automatic logic [26:0] model(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] m,
                                          input logic rst, input logic h);
        logic [7:0]  ctl;
        logic [15:0] p;
        logic [7:0]  r;
        logic        br;
        case (op)
            3'd0:    ctl = {2'b00, 6'b010010};
            3'd1:    ctl = {2'b01, 6'b010010};
            3'd2:    ctl = {2'b10, 6'b010010};
            3'd3:    ctl = {2'b00, 6'b010111};
            3'd4:    ctl = {2'b00, 6'b011000};
            3'd5:    ctl = {2'b11, 6'b110000};
            3'd6:    ctl = {2'b00, 6'b010000};
            default: ctl = {2'b00, 6'b000000};
        endcase
        if (!rst || h) ctl = 8'h00;
        p = 16'(a) * 16'(b);
        case (ctl[7:6])
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = p[7:0];
            default: r = a;
        endcase
        br = ctl[5] && (r != 8'h00) && !r[7];
        return {ctl, r, (r == 8'h00), br, (ctl[0] ? m : r), h};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] m);
        bus.opcode   = op;
        bus.alu_a    = a;
        bus.alu_b    = b;
        bus.mem_data = m;
    endtask

    task automatic compare(input string tag);
        logic [26:0] obs;
        logic [26:0] exp;
        obs = {bus.ula_op, bus.gz, bus.esc_pc, bus.esc_mem, bus.ler_mem, bus.esc_reg,
               bus.reg_fonte, bus.alu_out, bus.zero, bus.branch_taken, bus.wb_data,
               bus.halted};
        n_vec++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s scoreboard empty obs=%h exp=none", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
            end
        end
        $display("vec %0d %s op=%0d a=%h b=%h m=%h rst=%b -> %h", n_vec, tag,
                 bus.opcode, bus.alu_a, bus.alu_b, bus.mem_data, rst_n, obs);
    endtask

    task automatic apply(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] m);
        @(negedge clk);
        drive(op, a, b, m);
        #1;
        sb_q.push_back(model(op, a, b, m, rst_n, hm));
        compare(tag);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(3'd0, 8'h00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);

        // Reset state and reset dominance
        apply("rst_idle", 3'd0, 8'h00, 8'h00, 8'h00);
        chk("rst_halted", 8'(bus.halted), 8'h00);
        apply("rst_sw", 3'd4, 8'h12, 8'h34, 8'h56);
        chk("rst_esc_mem", 8'(bus.esc_mem), 8'h00);
        chk("rst_alu_live", bus.alu_out, 8'h46);
        apply("rst_halt0", 3'd7, 8'h01, 8'h02, 8'h00);
        apply("rst_halt1", 3'd7, 8'h01, 8'h02, 8'h00);
        apply("rst_halt2", 3'd7, 8'h01, 8'h02, 8'h00);
        chk("rst_halt_hold", 8'(bus.halted), 8'h00);

        // Release with HALT present: halts on the next edge
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb_q.push_back(model(3'd7, 8'h01, 8'h02, 8'h00, rst_n, hm));
        compare("rel_halt");
        apply("halt_set", 3'd7, 8'h01, 8'h02, 8'h00);
        chk("halt_flag", 8'(bus.halted), 8'h01);
        chk("halt_esc_pc", 8'(bus.esc_pc), 8'h00);
        apply("halted_add", 3'd0, 8'h07, 8'h01, 8'h00);
        chk("halted_esc_reg", 8'(bus.esc_reg), 8'h00);
        chk("halted_esc_pc", 8'(bus.esc_pc), 8'h00);
        chk("halted_alu", bus.alu_out, 8'h08);

        // Reset pulse between edges clears halt immediately
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("pulse_halted", 8'(bus.halted), 8'h00);
        rst_n = 1'b1;
        drive(3'd0, 8'h03, 8'h04, 8'h00);
        #1;
        chk("pulse_esc_reg", 8'(bus.esc_reg), 8'h01);
        sb_q.push_back(model(3'd0, 8'h03, 8'h04, 8'h00, rst_n, hm));
        compare("pulse_add");

        // Decode sweep (HALT excluded so halted stays 0)
        for (int i = 0; i < 7; i++) begin
            apply("sweep", 3'(i), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        // Arithmetic
        apply("add_wrap", 3'd0, 8'd200, 8'd100, 8'h00);
        chk("add_wrap_v", bus.alu_out, 8'd44);
        chk("add_wrap_z", 8'(bus.zero), 8'h00);
        apply("sub_zero", 3'd1, 8'd5, 8'd5, 8'h00);
        chk("sub_zero_z", 8'(bus.zero), 8'h01);
        apply("mul_wrap", 3'd2, 8'd16, 8'd16, 8'h00);
        chk("mul_wrap_z", 8'(bus.zero), 8'h01);
        apply("mul", 3'd2, 8'd5, 8'd24, 8'h00);
        chk("mul_v", bus.alu_out, 8'd120);

        // Branch
        apply("bgz_pos", 3'd5, 8'd3, 8'd9, 8'h00);
        chk("bgz_pos_t", 8'(bus.branch_taken), 8'h01);
        apply("bgz_zero", 3'd5, 8'd0, 8'd9, 8'h00);
        chk("bgz_zero_t", 8'(bus.branch_taken), 8'h00);
        apply("bgz_neg", 3'd5, 8'h80, 8'd9, 8'h00);
        chk("bgz_neg_t", 8'(bus.branch_taken), 8'h00);
        apply("add_nobr", 3'd0, 8'd3, 8'd0, 8'h00);
        chk("add_nobr_t", 8'(bus.branch_taken), 8'h00);

        // Write-back
        apply("lw", 3'd3, 8'd7, 8'd1, 8'hA5);
        chk("lw_wb", bus.wb_data, 8'hA5);
        chk("lw_src", 8'({bus.reg_fonte, bus.ler_mem}), 8'h03);
        apply("add_wb", 3'd0, 8'd7, 8'd1, 8'hA5);
        chk("add_wb_v", bus.wb_data, 8'd8);

        // Random non-halting traffic
        for (int i = 0; i < 20; i++) begin
            apply("rand", 3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom),
                  8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
